aes_byte_stream_loader: RTL
===========================

Name: aes_byte_stream_loader

Overview:
- Byte-serial front/back end for the combinational 128-bit AES encryption core (`main`: data, key -> en_key).
- Accepts plaintext and key bytes over a valid/ready stream and assembles the 128-bit data and key words that drive the core.
- Holds those words stable for a settle window, then captures en_key.
- Returns the ciphertext as a byte stream over a second valid/ready port.

Parameters:
- SETTLE_CYCLES, 2: clock cycles data/key are held stable before en_key is captured (legal range 1..15).
- BYTE_W, 8: stream byte width; fixed at 8, any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input byte valid
- in_ready  output  1  loader can accept a byte
- in_byte  input  8  input byte, most-significant byte first
- key_hold  input  1  sampled with last data byte; 1 = reuse previous key, skip key load
- core_data  output  128  plaintext word to core `data`
- core_key  output  128  key word to core `key`
- core_en_key  input  128  ciphertext from core `en_key`
- out_valid  output  1  output byte valid
- out_ready  input  1  downstream accepts output byte
- out_byte  output  8  ciphertext byte, most-significant byte first
- busy  output  1  high in any state other than LOAD_DATA with byte count 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = LOAD_DATA, byte_cnt = 0, settle_cnt = 0, key_valid = 0.
  - core_data, core_key, the internal ciphertext register, out_byte = 0.
  - out_valid = 0, busy = 0, in_ready = 0 while rst_n is low.
- in_ready is high in LOAD_DATA and LOAD_KEY, low otherwise.
- A byte transfers when in_valid & in_ready at a rising edge. out_byte transfers when out_valid & out_ready.
- States:
  - LOAD_DATA: each transfer shifts the byte into core_data from the LSB end (core_data <= {core_data[119:0], in_byte}) and increments byte_cnt. On the 16th transfer (byte_cnt == 15):
    - if key_hold & key_valid: go to SETTLE.
    - else: go to LOAD_KEY.
    - byte_cnt wraps to 0 either way.
  - key_hold with key_valid == 0 (no key loaded since reset) is ignored; LOAD_KEY is entered.
  - LOAD_KEY: same shifting into core_key. On the 16th transfer, set key_valid = 1, byte_cnt = 0, go to SETTLE.
  - SETTLE: core_data and core_key are frozen. settle_cnt counts 0..SETTLE_CYCLES-1. On the cycle settle_cnt == SETTLE_CYCLES-1:
    - capture core_en_key into the ciphertext register;
    - go to DRAIN with out_valid = 1 and out_byte = ciphertext[127:120] on the next cycle.
  - DRAIN: on each out transfer, shift the ciphertext register left by 8 and increment byte_cnt. After the 16th transfer (byte_cnt == 15):
    - out_valid drops, byte_cnt = 0, go to LOAD_DATA;
    - in_ready rises on the following cycle (no same-cycle overlap).
- out_valid stability: once asserted, out_valid and out_byte stay stable until out_ready; out_ready low stalls indefinitely.
- Latency: last input byte accepted at edge N -> first out_valid at edge N+SETTLE_CYCLES+1 (out_ready held high, key_hold path or last key byte).
- core_data and core_key are not cleared after a block: core_data keeps the last plaintext, core_key the last key.
- in_valid is ignored outside LOAD states; no bytes are dropped or buffered.
- Mid-operation reset: any state returns to the reset values immediately; a partial block is discarded and key_valid clears.
- The ciphertext register and all counters are registered outputs; no combinational path from in_byte to out_byte.

Decomposition:
- Package aes_pkg:
  - typedef aes_block_t (logic [127:0]);
  - typedef loader_state_t enum {LOAD_DATA, LOAD_KEY, SETTLE, DRAIN};
  - constant BYTES_PER_BLOCK = 16.
- One natural sub-module: aes_byte_shift128, a 128-bit byte shift register with load-parallel / shift-in / shift-out controls. It is instantiated for data, key and ciphertext.
- FSM and counters stay in the top.

Test Plan:
- FIPS-197 vector, out_ready = 1, core = `main`:
  - stimulus: data bytes 00 11 22 … ff, then key bytes 00 01 … 0f;
  - response: core_data = 00112233445566778899aabbccddeeff, core_key = 000102030405060708090a0b0c0d0e0f;
  - 16 output bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a;
  - first out_valid exactly SETTLE_CYCLES+1 edges after the last key byte.
- Key reuse: second block 112233445566778899aabbccddeeff00 with key_hold = 1 on its 16th byte -> no LOAD_KEY, in_ready low after the 16th byte, core_key unchanged, ciphertext equals core output for that pair.
- key_hold = 1 on the first block after reset -> key_hold ignored, LOAD_KEY entered, 16 key bytes required before any out_valid.
- Backpressure: toggle out_ready 1/0 every cycle and random in_valid gaps with an all-FF data/key block -> out_byte stable while out_valid & !out_ready, exactly 16 bytes out, byte order preserved.
- Reset asserted mid-DRAIN after 5 output bytes -> out_valid = 0, busy = 0, core_data = core_key = 0 immediately; the next full block produces correct all-zero-vector ciphertext 66e94bd4ef8a2c3b884cfa59ca342b2e.
- in_valid held high during SETTLE/DRAIN -> no bytes consumed (in_ready = 0); the first byte is accepted only on the cycle after the 16th output transfer.

Source files
------------

// File: rtl/aes_byte_stream_loader_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared types and constants for the byte-serial AES loader.
//   - aes_block_t     : one 128-bit AES block (plaintext, key or ciphertext)
//   - loader_state_t  : loader FSM states
//   - BYTES_PER_BLOCK : bytes in one 128-bit block
//   - is_load_state() : true for the states that accept input bytes
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    LOAD_DATA = 2'd0,
    LOAD_KEY  = 2'd1,
    SETTLE    = 2'd2,
    DRAIN     = 2'd3
  } loader_state_t;

  localparam int unsigned BYTES_PER_BLOCK = 16;

  // Byte counter value of the 16th byte of a block.
  localparam logic [3:0] LAST_BYTE_IDX = 4'(BYTES_PER_BLOCK - 1);

  // The input port is only open while a block or key is being assembled.
  function automatic logic is_load_state(input loader_state_t s);
    return (s == LOAD_DATA) || (s == LOAD_KEY);
  endfunction

endpackage

// File: rtl/aes_byte_stream_loader_shift128.sv
// ---------------------------------------------------------------------------
// aes_byte_shift128
//   128-bit register that moves one byte per cycle, MSB first.
//   Priority: parallel load > shift-in > shift-out > hold.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset (clears to 0)
//     i_load         : load i_load_word in parallel
//     i_load_word    : parallel load value
//     i_shift_in     : shift left one byte, i_byte enters at the LSB end
//     i_byte         : byte shifted in
//     i_shift_out    : shift left one byte, zero enters at the LSB end
//     o_word         : current register contents
// ---------------------------------------------------------------------------
module aes_byte_shift128
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [127:0] i_load_word,
  input  logic         i_shift_in,
  input  logic [7:0]   i_byte,
  input  logic         i_shift_out,
  output logic [127:0] o_word
);

  aes_block_t r_word;

  // Block register: parallel load, byte shift-in or byte shift-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= 128'd0;
    end else if (i_load) begin
      r_word <= i_load_word;
    end else if (i_shift_in) begin
      r_word <= {r_word[119:0], i_byte};
    end else if (i_shift_out) begin
      r_word <= {r_word[119:0], 8'h00};
    end else begin
      r_word <= r_word;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/aes_byte_stream_loader.sv
// ---------------------------------------------------------------------------
// aes_byte_stream_loader
//   Byte-serial wrapper around a combinational AES-128 encryption core.
//   Plaintext (and, unless reused, key) bytes arrive MSB first on a
//   valid/ready port and are assembled into core_data / core_key. After the
//   words have been held stable for SETTLE_CYCLES cycles the core result is
//   captured and returned MSB first on a second valid/ready port.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     in_valid/in_ready     : input byte handshake
//     in_byte               : input byte
//     key_hold              : with the 16th data byte, reuse the loaded key
//     core_data, core_key   : words driving the core
//     core_en_key           : core ciphertext
//     out_valid/out_ready   : output byte handshake
//     out_byte              : ciphertext byte
//     busy                  : any activity besides idle LOAD_DATA
// ---------------------------------------------------------------------------
module aes_byte_stream_loader
  import aes_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int BYTE_W        = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_byte,
  input  logic         key_hold,
  output logic [127:0] core_data,
  output logic [127:0] core_key,
  input  logic [127:0] core_en_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic         busy
);

  if (BYTE_W != 8) begin : g_byte_w_check
    $error("aes_byte_stream_loader: BYTE_W must be 8");
  end

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_settle_check
    $error("aes_byte_stream_loader: SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  // Registered state and outputs.
  loader_state_t r_state;
  logic [3:0]    r_byte_cnt;
  logic [3:0]    r_settle_cnt;
  logic          r_key_valid;
  logic          r_out_valid;
  logic          r_in_ready;
  logic          r_busy;

  // Next-state values and shifter strobes.
  loader_state_t w_next_state;
  logic [3:0]    w_next_byte_cnt;
  logic [3:0]    w_next_settle_cnt;
  logic          w_next_key_valid;
  logic          w_next_out_valid;
  logic          w_next_in_ready;
  logic          w_next_busy;
  logic          w_data_shift;
  logic          w_key_shift;
  logic          w_ct_load;
  logic          w_ct_shift;

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [127:0]  w_data_word;
  logic [127:0]  w_key_word;
  logic [127:0]  w_ct_word;
  logic [119:0]  w_ct_tail_unused;

  // in_ready is only ever high in the two load states, so this is the
  // complete acceptance condition.
  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  aes_byte_shift128 u_data_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (1'b0),
    .i_load_word (128'd0),
    .i_shift_in  (w_data_shift),
    .i_byte      (in_byte),
    .i_shift_out (1'b0),
    .o_word      (w_data_word)
  );

  aes_byte_shift128 u_key_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (1'b0),
    .i_load_word (128'd0),
    .i_shift_in  (w_key_shift),
    .i_byte      (in_byte),
    .i_shift_out (1'b0),
    .o_word      (w_key_word)
  );

  aes_byte_shift128 u_ct_sr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_ct_load),
    .i_load_word (core_en_key),
    .i_shift_in  (1'b0),
    .i_byte      (8'h00),
    .i_shift_out (w_ct_shift),
    .o_word      (w_ct_word)
  );

  // Only the top ciphertext byte leaves the block; the rest just feeds
  // the shift chain.
  assign w_ct_tail_unused = w_ct_word[119:0];

  // Next-state logic, counters and shifter strobes for the loader FSM.
  always_comb begin
    w_next_state      = r_state;
    w_next_byte_cnt   = r_byte_cnt;
    w_next_settle_cnt = r_settle_cnt;
    w_next_key_valid  = r_key_valid;
    w_next_out_valid  = 1'b0;
    w_data_shift      = 1'b0;
    w_key_shift       = 1'b0;
    w_ct_load         = 1'b0;
    w_ct_shift        = 1'b0;

    case (r_state)
      LOAD_DATA: begin
        if (w_in_xfer) begin
          w_data_shift = 1'b1;
          if (r_byte_cnt == LAST_BYTE_IDX) begin
            w_next_byte_cnt = 4'd0;
            // A held key is only honoured once a key has actually been loaded.
            if (key_hold && r_key_valid) begin
              w_next_state = SETTLE;
            end else begin
              w_next_state = LOAD_KEY;
            end
          end else begin
            w_next_byte_cnt = r_byte_cnt + 4'd1;
          end
        end else begin
          w_next_byte_cnt = r_byte_cnt;
        end
      end

      LOAD_KEY: begin
        if (w_in_xfer) begin
          w_key_shift = 1'b1;
          if (r_byte_cnt == LAST_BYTE_IDX) begin
            w_next_byte_cnt  = 4'd0;
            w_next_key_valid = 1'b1;
            w_next_state     = SETTLE;
          end else begin
            w_next_byte_cnt = r_byte_cnt + 4'd1;
          end
        end else begin
          w_next_byte_cnt = r_byte_cnt;
        end
      end

      SETTLE: begin
        // core_data/core_key are frozen here; the last settle cycle samples
        // the core output into the ciphertext register.
        if (r_settle_cnt == SETTLE_LAST) begin
          w_ct_load         = 1'b1;
          w_next_settle_cnt = 4'd0;
          w_next_state      = DRAIN;
        end else begin
          w_next_settle_cnt = r_settle_cnt + 4'd1;
        end
      end

      DRAIN: begin
        // out_valid rises one cycle after entering DRAIN, once the captured
        // top byte is already on out_byte.
        if (w_out_xfer) begin
          w_ct_shift = 1'b1;
          if (r_byte_cnt == LAST_BYTE_IDX) begin
            w_next_byte_cnt  = 4'd0;
            w_next_out_valid = 1'b0;
            w_next_state     = LOAD_DATA;
          end else begin
            w_next_byte_cnt  = r_byte_cnt + 4'd1;
            w_next_out_valid = 1'b1;
          end
        end else begin
          w_next_out_valid = 1'b1;
        end
      end

      default: begin
        w_next_state    = LOAD_DATA;
        w_next_byte_cnt = 4'd0;
      end
    endcase

    // Handshake and busy flags are registered from the next state so the
    // input port reopens only the cycle after the last output transfer.
    w_next_in_ready = is_load_state(w_next_state);
    w_next_busy     = !((w_next_state == LOAD_DATA) && (w_next_byte_cnt == 4'd0));
  end

  // FSM state, counters and registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LOAD_DATA;
      r_byte_cnt   <= 4'd0;
      r_settle_cnt <= 4'd0;
      r_key_valid  <= 1'b0;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_byte_cnt   <= w_next_byte_cnt;
      r_settle_cnt <= w_next_settle_cnt;
      r_key_valid  <= w_next_key_valid;
      r_out_valid  <= w_next_out_valid;
      r_in_ready   <= w_next_in_ready;
      r_busy       <= w_next_busy;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign core_data = w_data_word;
  assign core_key  = w_key_word;
  assign out_byte  = w_ct_word[127:120];

endmodule
